pwm_ramp_gen: RTL and testbench
===============================

# pwm_ramp_gen

Multi-channel soft-start PWM generator: a shared free-running period counter drives N_CH independent comparators. Each channel's duty cycle ramps toward a per-channel target in programmable steps at a programmable interval, up or down. Duty changes take effect only at PWM period boundaries, so no output pulse is truncated or stretched. It sits between the control registers and the output pins and supersedes the fixed 4-bit, ramp-up-only PWM generator.

## Interface
- CNT_W, 4: period counter and duty width; PWM period = 2**CNT_W clk cycles
- STEP_W, 12: step-interval timer width
- N_CH, 4: number of PWM channels
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = run; 0 = synchronous clear of timers, duties and outputs
- target_duty  in  N_CH*CNT_W  per-channel target; channel i at [i*CNT_W +: CNT_W]
- step_size  in  CNT_W  duty increment/decrement per tick, shared by all channels
- step_period  in  STEP_W  tick every step_period+1 cycles
- pwm_out  out  N_CH  registered PWM outputs
- at_target  out  N_CH  registered; 1 when channel's current duty equals its target
- busy  out  1  registered; OR of ~at_target while enable=1

## Operation
- Period counter `pcnt`: free-running 0..2**CNT_W-1, wraps to 0. `pend` = (pcnt == 2**CNT_W-1).
- Step timer `scnt`: counts 0..step_period, then reloads 0. `tick` = (scnt == step_period). If step_period = 0, tick fires every cycle. If step_period is lowered below the current scnt, the timer wraps to 0 through the full STEP_W range. No compare with >= is used.
- Per channel, `duty_cur` updates on tick:
  - cur < tgt: cur <= min(cur+step_size, tgt).
  - cur > tgt: cur <= max(cur-step_size, tgt).
  - equal: hold.
  - Arithmetic uses CNT_W+1 bits and saturates. The result never overflows, underflows or overshoots the target.
- Per channel, shadow `duty_eff` loads duty_cur when pend=1. It holds otherwise.
- pwm_out[i] <= (duty_eff[i] > pcnt). Consequences:
  - duty 0 gives a constant 0.
  - Maximum duty 2**CNT_W-1 gives a high time of (2**CNT_W-1)/2**CNT_W. A 100% duty cycle is not reachable, by design.
- target_duty may change at any time. The next tick moves toward the new value, including reversing direction mid-ramp.
- step_size = 0: duty_cur frozen.
- at_target[i] <= (duty_cur[i] == tgt[i]).
- enable = 0: pcnt, scnt, duty_cur, duty_eff, pwm_out and busy clear to 0 on the next edge. at_target tracks (0 == tgt).
- Re-enable restarts from duty 0 with pcnt = 0 and scnt = 0.

## Timing
- Reset (rst_n low, async): all registers are 0. Outputs: pwm_out = 0, busy = 0. at_target = 0 during reset. It then evaluates on the first edge after release.
- tick at edge k: duty_cur is new after edge k. It reaches duty_eff at the next pend edge. It reaches pwm_out one cycle after that pend edge, i.e. at the first cycle of the next period.
- tick and pend in the same cycle: duty_eff takes the old duty_cur. The new value waits one full period.
- pwm_out latency from pcnt is 1 cycle. Every pin sees the same pcnt, so channels are phase-aligned.
- at_target and busy lag duty_cur/target changes by 1 cycle.
- Reset asserted mid-ramp: immediate clear. There is no residual pulse.

## Structure
- Package pwm_pkg:
  - default CNT_W, STEP_W and N_CH constants
  - function `ramp_next(cur, tgt, step)` implementing the saturating toward-target step
- Sub-module pwm_ramp_channel, one per channel, generated N_CH times:
  - owns duty_cur, duty_eff, the comparator and at_target
  - inputs: pcnt, pend, tick, tgt, step_size, enable
- The top level owns pcnt, scnt, tick/pend generation and the busy reduction.

## Test plan
All scenarios use CNT_W=4, STEP_W=12, N_CH=4.
- Ramp up: step_size=2, step_period=3, tgt0=14 → duty_cur0 goes 0,2,4,…,14 every 4 cycles. at_target0 rises 1 cycle after 14 is reached. Measured high time per 16-cycle period equals duty_eff.
- Saturating step: tgt=7, step_size=3 → sequence 0,3,6,7, hold. Then tgt=1 → 7,4,1, hold. There is never an overshoot or wrap.
- Glitch-free update: tick and pend coincident → pwm_out pattern unchanged for that period. The new duty appears exactly 16 cycles later. Every period's high run is contiguous, starting at pcnt=0.
- Extremes: tgt=0 → pwm_out constant 0. tgt=15, step_size=15, step_period=0 → after settling, 15 high and 1 low per period.
- Independent channels: tgt = 4, 8, 12, 0 with step 4 → channels settle at 1, 2, 3 and 0 ticks respectively. busy drops 1 cycle after channel 2 settles.
- Reset/enable mid-ramp: rst_n low at duty 6 → pwm_out 0 immediately, all state 0. enable low for 1 cycle → all clear on the next edge. Re-enable ramps from 0, with the first tick step_period+1 cycles later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the saturating toward-target step used by every PWM ramp channel.
package pwm_pkg;
    localparam int CNT_W_DEF  = 4;
    localparam int STEP_W_DEF = 12;
    localparam int N_CH_DEF   = 4;

    // Widened operands keep cur+step from wrapping; result clamps at tgt in both directions.
    function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] step);
        logic [32:0] sum;
        logic [31:0] diff;
        ramp_next = cur;
        if (cur < tgt) begin
            sum       = {1'b0, cur} + {1'b0, step};
            ramp_next = (sum > {1'b0, tgt}) ? tgt : sum[31:0];
        end else if (cur > tgt) begin
            diff      = cur - tgt;
            ramp_next = (step > diff) ? tgt : cur - step;
        end
    endfunction
endpackage

// File: rtl/pwm_ramp_channel.sv
// One PWM lane: ramping duty, period-aligned shadow duty, comparator and at-target flag.
module pwm_ramp_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] pcnt,
    input  logic             pend,
    input  logic             tick,
    input  logic [CNT_W-1:0] tgt,
    input  logic [CNT_W-1:0] step_size,
    output logic             pwm_out,
    output logic             at_target,
    output logic             match
);
    logic [CNT_W-1:0] duty_cur, duty_eff, duty_nxt;

    assign duty_nxt = CNT_W'(ramp_next(32'(duty_cur), 32'(tgt), 32'(step_size)));
    assign match    = (duty_cur == tgt);

    // duty_eff only moves at the period boundary so no pulse is cut or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cur  <= '0;
            duty_eff  <= '0;
            pwm_out   <= 1'b0;
            at_target <= 1'b0;
        end else if (!enable) begin
            duty_cur  <= '0;
            duty_eff  <= '0;
            pwm_out   <= 1'b0;
            at_target <= (tgt == '0);
        end else begin
            if (tick) duty_cur <= duty_nxt;
            if (pend) duty_eff <= duty_cur;
            pwm_out   <= (duty_eff > pcnt);
            at_target <= match;
        end
    end
endmodule

// File: rtl/pwm_ramp_gen.sv
// Multi-channel soft-start PWM: shared period counter and step timer feeding N_CH ramp channels.
module pwm_ramp_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int N_CH   = N_CH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH*CNT_W-1:0] target_duty,
    input  logic [CNT_W-1:0]      step_size,
    input  logic [STEP_W-1:0]     step_period,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH-1:0]       at_target,
    output logic                  busy
);
    localparam logic [CNT_W-1:0] PCNT_MAX = '1;

    logic [CNT_W-1:0]  pcnt;
    logic [STEP_W-1:0] scnt;
    logic              pend, tick;
    logic [N_CH-1:0]   match;

    assign pend = (pcnt == PCNT_MAX);
    // Equality only: lowering step_period below scnt lets the timer run round the full range.
    assign tick = (scnt == step_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            scnt <= '0;
            busy <= 1'b0;
        end else if (!enable) begin
            pcnt <= '0;
            scnt <= '0;
            busy <= 1'b0;
        end else begin
            pcnt <= pcnt + 1'b1;
            scnt <= tick ? '0 : scnt + 1'b1;
            busy <= ~&match;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_ramp_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .pcnt      (pcnt),
            .pend      (pend),
            .tick      (tick),
            .tgt       (target_duty[i*CNT_W +: CNT_W]),
            .step_size (step_size),
            .pwm_out   (pwm_out[i]),
            .at_target (at_target[i]),
            .match     (match[i])
        );
    end
endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Bench for pwm_ramp_gen: cycle scoreboard against a unit-step model, a vector table and corner sequences.
module tb_pwm_ramp_gen;
    localparam int CNT_W = 4, STEP_W = 12, N_CH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [N_CH*CNT_W-1:0] target_duty = '0;
    logic [CNT_W-1:0]      step_size = '0;
    logic [STEP_W-1:0]     step_period = '0;
    logic [N_CH-1:0]       pwm_out, at_target;
    logic                  busy;

    int n_chk = 0, n_fail = 0;
    int hi[N_CH];

    always #5 clk = ~clk;

    pwm_ramp_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .N_CH(N_CH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .target_duty(target_duty),
        .step_size(step_size), .step_period(step_period),
        .pwm_out(pwm_out), .at_target(at_target), .busy(busy)
    );

    typedef struct packed {
        logic [N_CH-1:0] pwm;
        logic [N_CH-1:0] at;
        logic            busy;
    } obs_t;
    obs_t sb[$];

    int m_pcnt, m_scnt;
    int m_cur[N_CH], m_eff[N_CH];

    // Reference ramp: walks one unit at a time, stopping on the target.
    function automatic int toward(input int c, input int t, input int s);
        int r;
        r = c;
        for (int k = 0; k < s; k++) begin
            if (r < t) r++;
            else if (r > t) r--;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        obs_t e;
        int   t;
        logic tk;
        if (!rst_n) begin
            m_pcnt = 0;
            m_scnt = 0;
            for (int i = 0; i < N_CH; i++) begin m_cur[i] = 0; m_eff[i] = 0; end
        end else begin
            e = '0;
            if (!enable) begin
                for (int i = 0; i < N_CH; i++) begin
                    e.at[i] = (target_duty[i*CNT_W +: CNT_W] == 0);
                    m_cur[i] = 0;
                    m_eff[i] = 0;
                end
                m_pcnt = 0;
                m_scnt = 0;
            end else begin
                tk = (m_scnt == int'(step_period));
                for (int i = 0; i < N_CH; i++) begin
                    t = int'(target_duty[i*CNT_W +: CNT_W]);
                    e.pwm[i] = (m_eff[i] > m_pcnt);
                    e.at[i]  = (m_cur[i] == t);
                    if (m_cur[i] != t) e.busy = 1'b1;
                    if (m_pcnt == 15) m_eff[i] = m_cur[i];
                    if (tk) m_cur[i] = toward(m_cur[i], t, int'(step_size));
                end
                m_pcnt = (m_pcnt + 1) % 16;
                m_scnt = tk ? 0 : (m_scnt + 1) % 4096;
            end
            sb.push_back(e);
        end
    end

    always @(posedge clk) begin
        obs_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({pwm_out, at_target, busy} !== e) begin
                n_fail++;
                $display("FAIL sb @%0t: got pwm=%b at=%b busy=%b, want pwm=%b at=%b busy=%b",
                         $time, pwm_out, at_target, busy, e.pwm, e.at, e.busy);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic restart(input logic [15:0] t, input logic [3:0] s, input logic [11:0] p);
        @(negedge clk);
        enable = 1'b0; target_duty = t; step_size = s; step_period = p;
        @(negedge clk);
        enable = 1'b1;
    endtask

    // Returns the 1-based edge index at which at_target[0] first reads 1 (0 on timeout).
    task automatic edges_until_at0(output int n);
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (at_target[0]) begin n = k; break; end
        end
    endtask

    task automatic measure();
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N_CH; i++) hi[i] += int'(pwm_out[i]);
        end
    endtask

    typedef struct packed {
        logic [15:0]     tgt;
        logic [3:0]      step;
        logic [11:0]     per;
        logic [3:0]      at;
        logic            busy;
        logic [3:0][4:0] hi;
    } vec_t;
    vec_t vt[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, f1, fb, run;
        logic pw[1:48];

        vt[0] = '{tgt:16'h000E, step:4'd2,  per:12'd3, at:4'hF, busy:1'b0, hi:{5'd0, 5'd0, 5'd0, 5'd14}};
        vt[1] = '{tgt:16'h0C84, step:4'd4,  per:12'd0, at:4'hF, busy:1'b0, hi:{5'd0, 5'd12, 5'd8, 5'd4}};
        vt[2] = '{tgt:16'hFFFF, step:4'd15, per:12'd0, at:4'hF, busy:1'b0, hi:{5'd15, 5'd15, 5'd15, 5'd15}};
        vt[3] = '{tgt:16'h0007, step:4'd3,  per:12'd5, at:4'hF, busy:1'b0, hi:{5'd0, 5'd0, 5'd0, 5'd7}};
        vt[4] = '{tgt:16'h0009, step:4'd0,  per:12'd2, at:4'hE, busy:1'b1, hi:{5'd0, 5'd0, 5'd0, 5'd0}};

        #2;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_at", int'(at_target), 0);
        check("reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ramp up by 2 every 4 cycles to 14: reaches 14 on edge 28, flag on edge 29.
        restart(16'h000E, 4'd2, 12'd3);
        edges_until_at0(n);
        check("ramp_at0_edge", n, 29);

        // Async reset while a pulse is high.
        restart(16'h000E, 4'd2, 12'd3);
        repeat (18) begin @(posedge clk); #1; end
        check("pre_reset_pwm0", int'(pwm_out[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_out), 0);
        check("async_rst_at", int'(at_target), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        edges_until_at0(n);
        check("post_reset_at0_edge", n, 29);

        // One-cycle enable drop mid-ramp, then a full restart from duty 0.
        restart(16'h000E, 4'd2, 12'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check("en_low_pwm", int'(pwm_out), 0);
        check("en_low_busy", int'(busy), 0);
        check("en_low_at", int'(at_target), 4'hE);
        @(negedge clk);
        enable = 1'b1;
        edges_until_at0(n);
        check("reenable_at0_edge", n, 29);

        // Independent channels: 4/8/12/0 settle after 1/2/3/0 ticks.
        restart(16'h0C84, 4'd4, 12'd3);
        f0 = 0; f1 = 0; fb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (f0 == 0 && at_target[0]) f0 = k;
            if (f1 == 0 && at_target[1]) f1 = k;
            if (fb == 0 && !busy) fb = k;
        end
        check("indep_at0_edge", f0, 5);
        check("indep_at1_edge", f1, 9);
        check("indep_busy_drop", fb, 13);

        // Tick coincides with pend: first period stays empty, new duty one period later.
        restart(16'h000F, 4'd5, 12'd15);
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk); #1;
            pw[k] = pwm_out[0];
        end
        n = 0;
        for (int k = 1; k <= 32; k++) n += int'(pw[k]);
        check("glitch_first_two_periods", n, 0);
        n = 0;
        for (int k = 33; k <= 48; k++) n += int'(pw[k]);
        check("glitch_third_period_high", n, 5);
        run = 0;
        for (int k = 33; k <= 48; k++) begin
            if (!pw[k]) break;
            run++;
        end
        check("glitch_contiguous_run", run, 5);

        for (int v = 0; v < 5; v++) begin
            restart(vt[v].tgt, vt[v].step, vt[v].per);
            repeat (300) @(posedge clk);
            #1;
            check($sformatf("vec%0d_at", v), int'(at_target), int'(vt[v].at));
            check($sformatf("vec%0d_busy", v), int'(busy), int'(vt[v].busy));
            measure();
            for (int i = 0; i < N_CH; i++)
                check($sformatf("vec%0d_high_ch%0d", v, i), hi[i], int'(vt[v].hi[i]));
        end

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
